// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter in front of a shared ripple-carry add/sub unit
// with a single registered result slot. Optional condition-code outputs: ADDSUB_ARB_CC_EN.
module addsub_arbiter #(
  parameter int   WIDTH     = 64,
  parameter logic INIT_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  // Handshake: a transfer completes in any cycle where valid and ready are both high;
  // requesters hold operands stable while valid and not ready.
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_ovf,
`ifdef ADDSUB_ARB_CC_EN
  output logic             rsp_zf,
  output logic             rsp_sf,
`endif
  output logic             dbg_slot_state_o,
  output logic             dbg_last_grant_o
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_ovf_q, rsp_ovf_d;
`ifdef ADDSUB_ARB_CC_EN
  logic             rsp_zf_q, rsp_zf_d;
  logic             rsp_sf_q, rsp_sf_d;
`endif

  logic             slot_free;
  logic             granted;
  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic             ovf;

  // Contention goes to whoever did not win the last accepted transfer.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign granted    = req0_valid | req1_valid;
  assign slot_free  = (state_q == S_EMPTY) || rsp_ready;
  assign req0_ready = !rst && slot_free && req0_valid && (grant == 1'b0);
  assign req1_ready = !rst && slot_free && req1_valid && (grant == 1'b1);
  assign accept     = req0_ready | req1_ready;

  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_sub = 1'b0;
    if (granted) begin
      if (grant) begin
        op_a   = req1_a;
        op_b   = req1_b;
        op_sub = req1_sub;
      end else begin
        op_a   = req0_a;
        op_b   = req0_b;
        op_sub = req0_sub;
      end
    end
  end

  // Subtraction is A + ~B + 1, so the op bit doubles as carry-in.
  always_comb begin
    b_eff    = op_b ^ {WIDTH{op_sub}};
    carry    = '0;
    carry[0] = op_sub;
    sum      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]     = op_a[i] ^ b_eff[i] ^ carry[i];
      carry[i+1] = (op_a[i] & b_eff[i]) | (carry[i] & (op_a[i] ^ b_eff[i]));
    end
  end

  assign ovf = carry[WIDTH] ^ carry[WIDTH-1];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_ovf_d    = rsp_ovf_q;
`ifdef ADDSUB_ARB_CC_EN
    rsp_zf_d     = rsp_zf_q;
    rsp_sf_d     = rsp_sf_q;
`endif
    if (accept) begin
      state_d      = S_FULL;
      last_grant_d = grant;
      rsp_id_d     = grant;
      rsp_sum_d    = sum;
      rsp_ovf_d    = ovf;
`ifdef ADDSUB_ARB_CC_EN
      rsp_zf_d     = (sum == '0);
      rsp_sf_d     = sum[WIDTH-1];
`endif
    end else if ((state_q == S_FULL) && rsp_ready) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      last_grant_q <= ~INIT_PRIO;
      rsp_id_q     <= 1'b0;
      rsp_sum_q    <= '0;
      rsp_ovf_q    <= 1'b0;
`ifdef ADDSUB_ARB_CC_EN
      rsp_zf_q     <= 1'b0;
      rsp_sf_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_ovf_q    <= rsp_ovf_d;
`ifdef ADDSUB_ARB_CC_EN
      rsp_zf_q     <= rsp_zf_d;
      rsp_sf_q     <= rsp_sf_d;
`endif
    end
  end

  assign rsp_valid        = (state_q == S_FULL);
  assign rsp_id           = rsp_id_q;
  assign rsp_sum          = rsp_sum_q;
  assign rsp_ovf          = rsp_ovf_q;
`ifdef ADDSUB_ARB_CC_EN
  assign rsp_zf           = rsp_zf_q;
  assign rsp_sf           = rsp_sf_q;
`endif
  assign dbg_slot_state_o = state_q;
  assign dbg_last_grant_o = last_grant_q;

endmodule
